// File: rtl/adder_pkg.sv
// adder_pkg: shared constants, the stage-count helper and the per-stage carry/valid bundle.
package adder_pkg;
   localparam int ADDER_DEFAULT_CHUNK = 4;
   typedef struct packed {
      logic c;
      logic v;
   } stage_cv_t;
   function automatic int stage_count(input int width, input int chunk);
      return width / chunk;
   endfunction
endpackage

// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: streaming operand/result bundle for pipelined_adder.
// slave is the adder side, master the producer/consumer side.
// Signals: i_valid/o_ready/i_a/i_b (operands in), o_valid/i_ready/o_sum/o_carry (result out),
// o_ovf (signed overflow) only when PIPELINED_ADDER_OVF_EN is defined.
interface pipelined_adder_if #(parameter int WIDTH = 16);
   logic i_valid;
   logic o_ready;
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic o_valid;
   logic i_ready;
   logic [WIDTH-1:0] o_sum;
   logic o_carry;
`ifdef PIPELINED_ADDER_OVF_EN
   logic o_ovf;
   modport slave (input i_valid, i_a, i_b, i_ready, output o_ready, o_valid, o_sum, o_carry, o_ovf);
   modport master (output i_valid, i_a, i_b, i_ready, input o_ready, o_valid, o_sum, o_carry, o_ovf);
`else
   modport slave (input i_valid, i_a, i_b, i_ready, output o_ready, o_valid, o_sum, o_carry);
   modport master (output i_valid, i_a, i_b, i_ready, input o_ready, o_valid, o_sum, o_carry);
`endif
endinterface

// File: rtl/adder_slice.sv
// adder_slice: one CHUNK-bit registered add with carry-in/out and valid, advancing when en_i is high.
// Ports: clk, rst (sync, active-high), en_i, a_i, b_i, cv_i (carry-in + valid-in),
// sum_o, cv_o (registered carry-out + valid-out).
module adder_slice
   import adder_pkg::*;
#(
   parameter int CHUNK = ADDER_DEFAULT_CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  stage_cv_t        cv_i,
   output logic [CHUNK-1:0] sum_o,
   output stage_cv_t        cv_o
);
   logic [CHUNK-1:0] sum_d, sum_q;
   logic c_d;
   stage_cv_t cv_d, cv_q;
   always_comb begin
      {c_d, sum_d} = {1'b0, a_i} + {1'b0, b_i} + (CHUNK+1)'(cv_i.c);
      cv_d = '{c: c_d, v: cv_i.v};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q <= '0;
         cv_q  <= '0;
      end else if (en_i) begin
         sum_q <= sum_d;
         cv_q  <= cv_d;
      end
   end
   assign sum_o = sum_q;
   assign cv_o  = cv_q;
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit unsigned adder, CHUNK bits per stage, valid/ready with global stall.
// Ports: i_clk, i_rst (sync, active-high), bus (pipelined_adder_if.slave: operands in, result out).
// Optional macro PIPELINED_ADDER_OVF_EN adds bus.o_ovf (signed overflow, aligned with o_sum).
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = ADDER_DEFAULT_CHUNK
) (
   input logic              i_clk,
   input logic              i_rst,
   pipelined_adder_if.slave bus
);
   localparam int STAGES = stage_count(WIDTH, CHUNK);
   if (WIDTH % CHUNK != 0) begin : g_chk
      $error("pipelined_adder: WIDTH must be a multiple of CHUNK");
   end
   logic adv;
   logic [WIDTH-1:0] op_a [STAGES];
   logic [WIDTH-1:0] op_b [STAGES];
   logic [WIDTH-1:0] a_q  [STAGES];
   logic [WIDTH-1:0] b_q  [STAGES];
   logic [WIDTH-1:0] lo_q [STAGES];
   logic [WIDTH-1:0] part [STAGES];
   logic [CHUNK-1:0] sl   [STAGES];
   stage_cv_t cv_in [STAGES];
   stage_cv_t cv    [STAGES];
   // The whole pipeline moves as one; only a held result blocks it.
   assign adv = !bus.o_valid || bus.i_ready;
   assign bus.o_ready = adv;
   for (genvar k = 0; k < STAGES; k++) begin : g_st
      if (k == 0) begin : g_first
         assign op_a[k]  = bus.i_a;
         assign op_b[k]  = bus.i_b;
         assign cv_in[k] = '{c: 1'b0, v: bus.i_valid};
      end else begin : g_next
         assign op_a[k]  = a_q[k-1];
         assign op_b[k]  = b_q[k-1];
         assign cv_in[k] = cv[k-1];
      end
      adder_slice #(.CHUNK(CHUNK)) u_slice (
         .clk  (i_clk),
         .rst  (i_rst),
         .en_i (adv),
         .a_i  (op_a[k][k*CHUNK +: CHUNK]),
         .b_i  (op_b[k][k*CHUNK +: CHUNK]),
         .cv_i (cv_in[k]),
         .sum_o(sl[k]),
         .cv_o (cv[k])
      );
      // lo_q[k] only ever holds slices below k, so OR-ing slice k in is exact.
      assign part[k] = lo_q[k] | (WIDTH'(sl[k]) << (k*CHUNK));
   end
   // Operands skew forward alongside the carry; finished lower slices deskew alongside it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]  <= '0;
            b_q[k]  <= '0;
            lo_q[k] <= '0;
         end
      end else if (adv) begin
         lo_q[0] <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= op_a[k];
            b_q[k] <= op_b[k];
         end
         for (int k = 1; k < STAGES; k++) lo_q[k] <= part[k-1];
      end
   end
   assign bus.o_valid = cv[STAGES-1].v;
   assign bus.o_carry = cv[STAGES-1].c;
   assign bus.o_sum   = part[STAGES-1];
`ifdef PIPELINED_ADDER_OVF_EN
   // Last-stage skew registers hold the operand MSBs aligned with o_sum.
   logic a_msb, b_msb;
   assign a_msb = a_q[STAGES-1][WIDTH-1];
   assign b_msb = b_q[STAGES-1][WIDTH-1];
   assign bus.o_ovf = (a_msb == b_msb) && (part[STAGES-1][WIDTH-1] != a_msb);
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: self-checking bench for pipelined_adder (WIDTH=16 with CHUNK=4 and CHUNK=16).
module tb_pipelined_adder;
   localparam int W = 16;
   localparam int S = 4;
   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] sum;
      logic carry;
      logic ovf;
   } vec_t;
   typedef struct {
      logic [W:0] r;
      logic ovf;
      int e;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   int advs = 0;
   exp_t q[$];
   vec_t tbl[7];
   always #5 clk = ~clk;
   pipelined_adder_if #(.WIDTH(W)) bus ();
   pipelined_adder_if #(.WIDTH(W)) bus1 ();
   pipelined_adder #(.WIDTH(W), .CHUNK(4)) u_dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );
   pipelined_adder #(.WIDTH(W), .CHUNK(16)) u_dut1 (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus1)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // Reference: every accepted pair must emerge in order after exactly S advancing cycles.
   task automatic mon();
      logic adv, exp_v;
      int sa;
      exp_t e;
      if (rst) begin
         q.delete();
         return;
      end
      adv = !bus.o_valid || bus.i_ready;
      chk("o_ready", 32'(bus.o_ready), 32'(adv));
      exp_v = q.size() > 0 && q[0].e + S == advs;
      chk("o_valid", 32'(bus.o_valid), 32'(exp_v));
      if (bus.o_valid && exp_v) begin
         chk("o_sum", 32'(bus.o_sum), 32'(q[0].r[W-1:0]));
         chk("o_carry", 32'(bus.o_carry), 32'(q[0].r[W]));
`ifdef PIPELINED_ADDER_OVF_EN
         chk("o_ovf", 32'(bus.o_ovf), 32'(q[0].ovf));
`endif
         if (bus.i_ready) void'(q.pop_front());
      end
      if (bus.i_valid && bus.o_ready) begin
         sa = $signed(bus.i_a) + $signed(bus.i_b);
         e.r = {1'b0, bus.i_a} + {1'b0, bus.i_b};
         e.ovf = sa > 32767 || sa < -32768;
         e.e = advs;
         q.push_back(e);
      end
      if (adv) advs++;
   endtask
   task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic rdy, input logic r = 1'b0);
      @(negedge clk);
      rst = r;
      bus.i_valid = v;
      bus.i_a = a;
      bus.i_b = b;
      bus.i_ready = rdy;
      #1;
      mon();
   endtask
   task automatic idle();
      drive(1'b0, W'($urandom), W'($urandom), 1'b1);
   endtask
   initial begin
      tbl[0] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
      tbl[1] = '{16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0};
      tbl[2] = '{16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
      tbl[3] = '{16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
      tbl[4] = '{16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0};
      tbl[5] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0};
      tbl[6] = '{16'h0F0F, 16'h00F1, 16'h1000, 1'b0, 1'b0};
      bus1.i_valid = 1'b0;
      bus1.i_a = '0;
      bus1.i_b = '0;
      bus1.i_ready = 1'b1;
      drive(1'b0, '0, '0, 1'b1, 1'b1);
      drive(1'b0, '0, '0, 1'b1, 1'b1);
      idle();
      chk("rst_valid", 32'(bus.o_valid), 0);
      chk("rst_sum", 32'(bus.o_sum), 0);
      chk("rst_carry", 32'(bus.o_carry), 0);
      chk("rst_valid16", 32'(bus1.o_valid), 0);
      chk("rst_sum16", 32'(bus1.o_sum), 0);
      chk("rst_carry16", 32'(bus1.o_carry), 0);
      // Isolated vectors: result must show up exactly S cycles after acceptance.
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, tbl[i].a, tbl[i].b, 1'b1);
         repeat (S) idle();
         chk("tbl_valid", 32'(bus.o_valid), 1);
         chk("tbl_sum", 32'(bus.o_sum), 32'(tbl[i].sum));
         chk("tbl_carry", 32'(bus.o_carry), 32'(tbl[i].carry));
`ifdef PIPELINED_ADDER_OVF_EN
         chk("tbl_ovf", 32'(bus.o_ovf), 32'(tbl[i].ovf));
`endif
      end
      repeat (2) idle();
      // Back-to-back stream of 8 pairs.
      for (int i = 0; i < 8; i++) drive(1'b1, W'(16'h1234 * (i + 1)), 16'h1111, 1'b1);
      repeat (S + 2) idle();
      chk("stream_drain", 32'(q.size()), 0);
      // Backpressure for 3 cycles as the first result appears.
      for (int i = 0; i < 4; i++) drive(1'b1, W'($urandom), W'($urandom), 1'b1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, W'($urandom), W'($urandom), 1'b0);
         chk("bp_ready", 32'(bus.o_ready), 0);
         chk("bp_valid", 32'(bus.o_valid), 1);
      end
      repeat (S + 6) idle();
      chk("bp_drain", 32'(q.size()), 0);
      // Reset in flight: nothing may emerge afterwards.
      drive(1'b1, 16'h0101, 16'h0202, 1'b1);
      drive(1'b1, 16'h0303, 16'h0404, 1'b1);
      drive(1'b1, 16'h0505, 16'h0606, 1'b1, 1'b1);
      repeat (6) begin
         idle();
         chk("rst_flight", 32'(bus.o_valid), 0);
      end
      drive(1'b1, 16'h0003, 16'h0004, 1'b1);
      repeat (S - 1) idle();
      chk("post_rst_early", 32'(bus.o_valid), 0);
      idle();
      chk("post_rst_valid", 32'(bus.o_valid), 1);
      chk("post_rst_sum", 32'(bus.o_sum), 32'h7);
      // Single-stage variant: latency 1.
      idle();
      bus1.i_valid = 1'b1;
      bus1.i_a = 16'h8000;
      bus1.i_b = 16'h8000;
      chk("c16_pre", 32'(bus1.o_valid), 0);
      idle();
      bus1.i_valid = 1'b0;
      chk("c16_valid", 32'(bus1.o_valid), 1);
      chk("c16_sum", 32'(bus1.o_sum), 0);
      chk("c16_carry", 32'(bus1.o_carry), 1);
`ifdef PIPELINED_ADDER_OVF_EN
      chk("c16_ovf", 32'(bus1.o_ovf), 1);
`endif
      idle();
      chk("c16_post", 32'(bus1.o_valid), 0);
      // Randomized traffic with random backpressure.
      for (int i = 0; i < 400; i++)
         drive(1'($urandom_range(3) != 0), W'($urandom), W'($urandom), 1'($urandom_range(2) != 0));
      repeat (S + 8) idle();
      chk("rand_drain", 32'(q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
